// File: rtl/inst_loader.sv
// inst_loader: programs instruction memory from a valid/ready word stream.
// A request is range-checked on entry, then the loader strobes the base
// address once, streams words into the write-data port, pulses the PC reset
// and optionally launches the core.
module inst_loader #(
   parameter  int RegAddrWidth     = 32,
   parameter  int InstMemDepth     = 128,
   localparam int InstMemAddrWidth = $clog2(InstMemDepth)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clr_i,
   input  logic                          load_start_i,
   input  logic                          load_abort_i,
   input  logic [RegAddrWidth-1:0]       load_base_addr_i,
   input  logic [RegAddrWidth-1:0]       load_len_i,
   input  logic                          load_auto_start_i,
   input  logic [RegAddrWidth-1:0]       data_i,
   input  logic                          data_valid_i,
   output logic                          data_ready_o,
   output logic                          inst_wr_mode_o,
   output logic [RegAddrWidth-1:0]       inst_wr_addr_o,
   output logic                          inst_wr_addr_en_o,
   output logic [RegAddrWidth-1:0]       inst_wr_data_o,
   output logic                          inst_wr_data_en_o,
   output logic                          inst_pc_reset_o,
   output logic                          core_start_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic [InstMemAddrWidth:0]     words_loaded_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET_ADDR,
      S_STREAM,
      S_FINISH,
      S_START
   } state_e;

   // Depth widened by one bit so base+len can be compared without wrapping.
   localparam logic [RegAddrWidth:0]     DepthExt = (RegAddrWidth+1)'(InstMemDepth);
   localparam logic [InstMemAddrWidth:0] CntOne   = {{InstMemAddrWidth{1'b0}}, 1'b1};

   state_e                      state_q, state_d;
   logic [InstMemAddrWidth-1:0] base_q,  base_d;
   logic [InstMemAddrWidth:0]   len_q,   len_d;
   logic [InstMemAddrWidth:0]   cnt_q,   cnt_d;
   logic                        auto_q,  auto_d;
   logic                        err_q,   err_d;

   logic [RegAddrWidth:0]       base_ext;
   logic [RegAddrWidth:0]       len_ext;
   logic [RegAddrWidth:0]       end_ext;
   logic                        req_bad;
   logic                        xfer;
   logic                        last_word;

   // Request validation and stream handshake decode.
   always_comb begin
      base_ext  = {1'b0, load_base_addr_i};
      len_ext   = {1'b0, load_len_i};
      end_ext   = base_ext + len_ext;
      req_bad   = (load_len_i == '0) || (base_ext >= DepthExt) || (end_ext > DepthExt);
      xfer      = (state_q == S_STREAM) && data_valid_i;
      last_word = (cnt_q == (len_q - CntOne));
   end

   // State and request registers; clear behaves exactly like reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value of its _d regardless of statement order.
      if (rst_i || clr_i) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         auto_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         auto_q  <= auto_d;
         err_q   <= err_d;
      end
   end

   // Next-state and next-register computation.
   always_comb begin
      // NOTE: every variable gets a hold default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      auto_d  = auto_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (load_start_i) begin
               if (req_bad) begin
                  err_d = 1'b1;
               end else begin
                  base_d  = load_base_addr_i[InstMemAddrWidth-1:0];
                  len_d   = load_len_i[InstMemAddrWidth:0];
                  auto_d  = load_auto_start_i;
                  err_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = S_SET_ADDR;
               end
            end
         end
         S_SET_ADDR: begin
            state_d = load_abort_i ? S_IDLE : S_STREAM;
         end
         S_STREAM: begin
            // A word accepted alongside an abort is still written and counted.
            if (xfer) cnt_d = cnt_q + CntOne;
            if (load_abort_i)          state_d = S_IDLE;
            else if (xfer && last_word) state_d = S_FINISH;
         end
         S_FINISH: begin
            state_d = auto_q ? S_START : S_IDLE;
         end
         S_START: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Per-state output decode; write data passes through only on a transfer.
   always_comb begin
      data_ready_o      = 1'b0;
      inst_wr_mode_o    = 1'b0;
      inst_wr_addr_en_o = 1'b0;
      inst_wr_data_o    = '0;
      inst_wr_data_en_o = 1'b0;
      inst_pc_reset_o   = 1'b0;
      core_start_o      = 1'b0;
      done_o            = 1'b0;
      unique case (state_q)
         S_IDLE: begin
         end
         S_SET_ADDR: begin
            inst_wr_mode_o    = 1'b1;
            inst_wr_addr_en_o = 1'b1;
         end
         S_STREAM: begin
            inst_wr_mode_o    = 1'b1;
            data_ready_o      = 1'b1;
            inst_wr_data_en_o = xfer;
            if (xfer) inst_wr_data_o = data_i;
         end
         S_FINISH: begin
            inst_pc_reset_o = 1'b1;
            done_o          = 1'b1;
         end
         S_START: begin
            core_start_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign inst_wr_addr_o = {{(RegAddrWidth-InstMemAddrWidth){1'b0}}, base_q};
   assign busy_o         = (state_q != S_IDLE);
   assign err_o          = err_q;
   assign words_loaded_o = cnt_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed, cycle-exact checks of the instruction loader.
module tb_inst_loader;

   // Packed control outputs: {mode, addr_en, data_en, ready, pc_reset, core_start, busy, done}
   localparam logic [7:0] O_IDLE  = 8'b0000_0000;
   localparam logic [7:0] O_SET   = 8'b1100_0010;
   localparam logic [7:0] O_XFER  = 8'b1011_0010;
   localparam logic [7:0] O_WAIT  = 8'b1001_0010;
   localparam logic [7:0] O_FIN   = 8'b0000_1011;
   localparam logic [7:0] O_START = 8'b0000_0110;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] base = '0;
   logic [31:0] len = '0;
   logic        auto_st = 1'b0;
   logic [31:0] data = '0;
   logic        valid = 1'b0;
   logic        ready;
   logic        wr_mode;
   logic [31:0] wr_addr;
   logic        wr_addr_en;
   logic [31:0] wr_data;
   logic        wr_data_en;
   logic        pc_reset;
   logic        core_start;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  words;

   int n_checks = 0;
   int n_errors = 0;

   inst_loader dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .clr_i             (clr),
      .load_start_i      (start),
      .load_abort_i      (abort),
      .load_base_addr_i  (base),
      .load_len_i        (len),
      .load_auto_start_i (auto_st),
      .data_i            (data),
      .data_valid_i      (valid),
      .data_ready_o      (ready),
      .inst_wr_mode_o    (wr_mode),
      .inst_wr_addr_o    (wr_addr),
      .inst_wr_addr_en_o (wr_addr_en),
      .inst_wr_data_o    (wr_data),
      .inst_wr_data_en_o (wr_data_en),
      .inst_pc_reset_o   (pc_reset),
      .core_start_o      (core_start),
      .busy_o            (busy),
      .done_o            (done),
      .err_o             (err),
      .words_loaded_o    (words)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] outs();
      return {wr_mode, wr_addr_en, wr_data_en, ready, pc_reset, core_start, busy, done};
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full load with valid held high; called from an IDLE cycle.
   task automatic do_load(input logic [31:0] b, input logic [31:0] l, input logic a,
                          input logic [31:0] d0);
      base = b; len = l; auto_st = a; start = 1'b1; valid = 1'b1; data = d0;
      #1 check("ld_idle", outs(), O_IDLE);
      tick(); start = 1'b0;
      #1 check("ld_set", outs(), O_SET);
      check("ld_addr", wr_addr, b);
      for (int i = 0; i < int'(l); i++) begin
         tick(); data = d0 + i;
         #1 check("ld_xfer", outs(), O_XFER);
         check("ld_data", wr_data, d0 + i);
      end
      tick(); valid = 1'b0;
      #1 check("ld_fin", outs(), O_FIN);
      check("ld_words", words, l);
      if (a) begin
         tick();
         #1 check("ld_start", outs(), O_START);
      end
      tick();
      #1 check("ld_end", outs(), O_IDLE);
      check("ld_err", err, 0);
   endtask

   // Rejected request: err set, loader never leaves IDLE.
   task automatic reject(input string tag, input logic [31:0] b, input logic [31:0] l);
      base = b; len = l; start = 1'b1; valid = 1'b1;
      tick(); start = 1'b0;
      #1 check(tag, outs(), O_IDLE);
      check(tag, err, 1);
      tick();
      #1 check(tag, outs(), O_IDLE);
      valid = 1'b0;
   endtask

   // Interrupt a 5-word load after two transfers with rst or clr.
   task automatic mid_reset(input logic use_clr);
      base = 32'd10; len = 32'd5; auto_st = 1'b1; valid = 1'b1; data = 32'hF0; start = 1'b1;
      tick(); start = 1'b0;
      #1 check("mr_set", outs(), O_SET);
      repeat (2) begin
         tick();
         #1 check("mr_xfer", outs(), O_XFER);
      end
      tick();
      if (use_clr) clr = 1'b1; else rst = 1'b1;
      tick(); rst = 1'b0; clr = 1'b0;
      #1 check("mr_outs", outs(), O_IDLE);
      check("mr_err", err, 0);
      check("mr_words", words, 0);
      check("mr_addr", wr_addr, 0);
      check("mr_data", wr_data, 0);
      do_load(32'd0, 32'd5, 1'b0, 32'hE0);
   endtask

   initial begin
      logic [5:0] pat;

      // Reset with live-looking stream inputs.
      rst = 1'b1; valid = 1'b1; data = 32'h55;
      repeat (2) tick();
      rst = 1'b0;
      #1 check("rst_outs", outs(), O_IDLE);
      check("rst_err", err, 0);
      check("rst_words", words, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_data", wr_data, 0);
      valid = 1'b0;

      // 1: basic load, base 0, 4 words 0xA0..0xA3.
      do_load(32'd0, 32'd4, 1'b0, 32'hA0);
      check("t1_words", words, 4);

      // 2: bubbled stream, base 10, 3 words.
      pat = 6'b101001;
      base = 32'd10; len = 32'd3; auto_st = 1'b0; valid = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      #1 check("t2_set", outs(), O_SET);
      check("t2_addr", wr_addr, 10);
      for (int i = 0; i < 6; i++) begin
         tick(); valid = pat[i]; data = 32'hB0 + i;
         #1 check("t2_cyc", outs(), pat[i] ? O_XFER : O_WAIT);
         if (pat[i]) check("t2_data", wr_data, 32'hB0 + i);
      end
      tick(); valid = 1'b0;
      #1 check("t2_fin", outs(), O_FIN);
      check("t2_words", words, 3);
      tick();
      #1 check("t2_idle", outs(), O_IDLE);

      // 3: bounds.
      do_load(32'd126, 32'd2, 1'b0, 32'h126);
      reject("t3_end_over", 32'd127, 32'd2);
      do_load(32'd5, 32'd2, 1'b0, 32'h50);
      reject("t3_len0", 32'd0, 32'd0);
      do_load(32'd3, 32'd1, 1'b0, 32'h30);
      reject("t3_base_over", 32'd128, 32'd1);
      do_load(32'd0, 32'd1, 1'b0, 32'h70);
      reject("t3_wrap", 32'd100, 32'hFFFF_FFF0);
      do_load(32'd0, 32'd128, 1'b0, 32'h1000);

      // 4: auto start, single word.
      do_load(32'd0, 32'd1, 1'b1, 32'hD0);

      // 5a: abort after 3 transfers with a start request in the abort cycle.
      base = 32'd20; len = 32'd8; auto_st = 1'b1; valid = 1'b1; data = 32'hC0; start = 1'b1;
      tick(); start = 1'b0;
      #1 check("t5_set", outs(), O_SET);
      for (int i = 0; i < 3; i++) begin
         tick(); data = 32'hC0 + i;
         #1 check("t5_xfer", outs(), O_XFER);
      end
      tick(); valid = 1'b0; abort = 1'b1; start = 1'b1;
      #1 check("t5_abort_cyc", outs(), O_WAIT);
      tick(); abort = 1'b0; start = 1'b0;
      #1 check("t5_idle", outs(), O_IDLE);
      check("t5_words", words, 3);
      tick();
      #1 check("t5_no_restart", outs(), O_IDLE);

      // 5b: abort coinciding with a transfer still counts that word.
      base = 32'd40; len = 32'd8; auto_st = 1'b0; valid = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); abort = 1'b1; data = 32'h99;
      #1 check("t5b_xfer", outs(), O_XFER);
      check("t5b_data", wr_data, 32'h99);
      tick(); abort = 1'b0; valid = 1'b0;
      #1 check("t5b_idle", outs(), O_IDLE);
      check("t5b_words", words, 1);

      // 6: reset, then clear, in the middle of a stream.
      mid_reset(1'b0);
      mid_reset(1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Sequencing controller that programs the instruction memory from a valid/ready word stream, such as a DMA or host FIFO.
- It drives the instruction-control write interface: write mode, write address, write data, PC reset and start.
- It sits between the stream source and the instruction control block, and replaces manual CSR-driven programming.
- After a load it resets the program counter and can optionally launch the core.

Parameters:
- RegAddrWidth, 32, width of instruction words, addresses and lengths.
- InstMemDepth, 128, number of instruction memory entries.
- InstMemAddrWidth, $clog2(InstMemDepth), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clr_i  in  1  synchronous clear; same effect as reset.
- load_start_i  in  1  pulse; request a load.
- load_abort_i  in  1  abort the load in progress.
- load_base_addr_i  in  RegAddrWidth  first instruction address.
- load_len_i  in  RegAddrWidth  number of words to load.
- load_auto_start_i  in  1  issue a core start after the load completes.
- data_i  in  RegAddrWidth  stream word.
- data_valid_i  in  1  stream valid.
- data_ready_o  out  1  stream ready.
- inst_wr_mode_o  out  1  instruction write mode.
- inst_wr_addr_o  out  RegAddrWidth  write address.
- inst_wr_addr_en_o  out  1  write address load strobe.
- inst_wr_data_o  out  RegAddrWidth  write data.
- inst_wr_data_en_o  out  1  write data strobe.
- inst_pc_reset_o  out  1  program counter reset pulse.
- core_start_o  out  1  core start pulse.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse on load completion.
- err_o  out  1  sticky error for a rejected request.
- words_loaded_o  out  InstMemAddrWidth+1  words accepted in the current or last load.

Behaviour:
- General:
  - Single clock domain; all state updates on posedge clk_i.
  - rst_i or clr_i has priority over everything. Either one returns to IDLE and zeroes all registers, err_o and words_loaded_o.
  - Reset value of every output is 0. This includes data_ready_o, all strobes, inst_wr_addr_o and inst_wr_data_o.
- States: IDLE, SET_ADDR, STREAM, FINISH, START.
- IDLE:
  - All strobes and data_ready_o are 0; inst_wr_mode_o is 0.
  - On load_start_i, validate the request using RegAddrWidth+1-bit arithmetic, so there is no wrap.
  - The request is rejected if load_len_i==0, or load_base_addr_i>=InstMemDepth, or load_base_addr_i+load_len_i>InstMemDepth.
  - On reject: set err_o and stay in IDLE; done_o is not pulsed.
  - On accept:
    - latch base, length and auto_start;
    - clear err_o and words_loaded_o;
    - go to SET_ADDR.
- SET_ADDR (exactly 1 cycle):
  - inst_wr_mode_o=1 and inst_wr_addr_en_o=1.
  - inst_wr_addr_o = latched base, zero-extended.
  - Go to STREAM.
- STREAM:
  - inst_wr_mode_o=1 and data_ready_o=1 (combinational from state).
  - A transfer occurs when data_valid_i && data_ready_o. In that cycle:
    - inst_wr_data_en_o=1;
    - inst_wr_data_o=data_i (combinational pass-through);
    - words_loaded_o increments.
  - A transfer when words_loaded_o==len-1 is the last one; go to FINISH.
  - If valid is low, hold the state with no strobe; bubbles are allowed indefinitely.
- FINISH (1 cycle):
  - inst_wr_mode_o=0, inst_pc_reset_o=1, done_o=1.
  - Go to START if auto_start was latched, else to IDLE.
- START (1 cycle):
  - core_start_o=1.
  - Go to IDLE.
- Abort:
  - load_abort_i in SET_ADDR or STREAM goes to IDLE next cycle. There is no done_o, no pc reset and no start.
  - A transfer coinciding with abort is still written and counted.
  - load_abort_i in FINISH or START is ignored.
- Other rules:
  - load_start_i while busy_o=1 is ignored; err_o is unchanged.
  - busy_o=1 in every state except IDLE; it drops in the cycle after FINISH or START.
  - Latency for len N with valid held high: start accepted at cycle 0 → addr strobe cycle 1 → data strobes cycles 2..N+1 → pc_reset/done cycle N+2 → core_start cycle N+3.
  - The inst_wr_addr_o value is meaningful only when inst_wr_addr_en_o=1; it holds the latched base otherwise.

Test Plan:
1. Basic load: base=0, len=4, auto_start=0, valid always high, data 0xA0..0xA3.
   - Required: addr_en at cycle 1; data_en at cycles 2-5 carrying 0xA0..0xA3; pc_reset and done at cycle 6.
   - Required: core_start never asserts; words_loaded_o=4.
2. Bubbled stream: base=10, len=3, valid toggling 1,0,0,1,0,1.
   - Required: exactly 3 data_en pulses, aligned with the valid-high cycles; inst_wr_addr_o=10 at addr_en.
   - Required: done 1 cycle after the third transfer.
3. Bounds: base=126, len=2 with Depth=128 → accepted, ending at address 127.
   - Then base=127, len=2 → err_o=1, busy_o stays 0, no strobes.
   - Then len=0 → err_o=1.
   - Then a valid request → err_o=0.
4. Auto start: base=0, len=1, auto_start=1.
   - Required: data_en at cycle 2, pc_reset at cycle 3, core_start at cycle 4, busy_o=0 at cycle 5.
5. Abort: len=8; assert load_abort_i after 3 transfers.
   - Required: IDLE next cycle, words_loaded_o=3, no done, no pc_reset, no core_start.
   - Required: load_start_i asserted during the abort cycle is ignored.
6. Reset/clear mid-STREAM: assert rst_i, then separately clr_i, after 2 of 5 words.
   - Required: all outputs 0 next cycle, err_o=0, words_loaded_o=0.
   - Required: a following load_start_i with base=0, len=5 completes normally.
